// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared pipeline types for the hazard/stall controller
package hazard_stall_ctrl_pkg;

    localparam int REG_SEL_W = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALTED  = 2'd2
    } pipeState_t;

    // Bundle ordering: PC, IF/ID en, IF/ID flush, ID/EX en, ID/EX flush, EX/MEM en, MEM/WB en
    typedef struct packed {
        logic pcEnable;
        logic ifidEnable;
        logic ifidFlush;
        logic idexEnable;
        logic idexFlush;
        logic exmemEnable;
        logic memwbEnable;
    } pipeCtrl_t;

    localparam pipeCtrl_t CTRL_RUN = '{
        pcEnable: 1'b1, ifidEnable: 1'b1, ifidFlush: 1'b0, idexEnable: 1'b1,
        idexFlush: 1'b0, exmemEnable: 1'b1, memwbEnable: 1'b1};
    localparam pipeCtrl_t CTRL_FREEZE = '{
        pcEnable: 1'b0, ifidEnable: 1'b0, ifidFlush: 1'b0, idexEnable: 1'b0,
        idexFlush: 1'b0, exmemEnable: 1'b0, memwbEnable: 1'b0};
    localparam pipeCtrl_t CTRL_REDIRECT = '{
        pcEnable: 1'b1, ifidEnable: 1'b1, ifidFlush: 1'b1, idexEnable: 1'b1,
        idexFlush: 1'b1, exmemEnable: 1'b1, memwbEnable: 1'b1};
    localparam pipeCtrl_t CTRL_BUBBLE = '{
        pcEnable: 1'b0, ifidEnable: 1'b0, ifidFlush: 1'b0, idexEnable: 1'b1,
        idexFlush: 1'b1, exmemEnable: 1'b1, memwbEnable: 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_match.sv
// rtl/hazard_stall_ctrl_match.sv - compares ID source registers against one destination
module hazard_match
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [REG_SEL_W-1:0] rs,
    input  logic                 rsUsed,
    input  logic [REG_SEL_W-1:0] rt,
    input  logic                 rtUsed,
    input  logic [REG_SEL_W-1:0] dest,
    output logic                 match
);

    // Register 0 is compared like any other register.
    assign match = (rsUsed && (rs == dest)) || (rtUsed && (rt == dest));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush/freeze/halt control with stall statistics
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int MAX_WAIT   = 64,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SEL_W-1:0] id_rs,
    input  logic                 id_rs_used,
    input  logic [REG_SEL_W-1:0] id_rt,
    input  logic                 id_rt_used,
    input  logic [REG_SEL_W-1:0] IDEX_WriteRegSel,
    input  logic                 IDEX_RegWrite,
    input  logic                 IDEX_MemToReg,
    input  logic [REG_SEL_W-1:0] EXMEM_WriteRegSel,
    input  logic                 EXMEM_RegWrite,
    input  logic                 ex_redirect,
    input  logic                 dmem_busy,
    input  logic                 mem_halt,
    output logic                 PC_enable,
    output logic                 IFID_enable,
    output logic                 IFID_flush,
    output logic                 IDEX_enable,
    output logic                 IDEX_flush,
    output logic                 EXMEM_enable,
    output logic                 MEMWB_enable,
    output logic                 halted,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    pipeState_t       state;
    logic [7:0]       waitCnt;
    logic [CNT_W-1:0] stallCnt;
    logic             memTimeout;
    logic             matchEx;
    logic             matchMem;
    logic             rawEx;
    logic             rawMem;
    logic             dataHaz;
    logic             bubbleCycle;
    pipeCtrl_t        ctrl;

    hazard_match u_matchEx (
        .rs     (id_rs),
        .rsUsed (id_rs_used),
        .rt     (id_rt),
        .rtUsed (id_rt_used),
        .dest   (IDEX_WriteRegSel),
        .match  (matchEx)
    );

    hazard_match u_matchMem (
        .rs     (id_rs),
        .rsUsed (id_rs_used),
        .rt     (id_rt),
        .rtUsed (id_rt_used),
        .dest   (EXMEM_WriteRegSel),
        .match  (matchMem)
    );

    assign rawEx   = IDEX_RegWrite & matchEx;
    assign rawMem  = EXMEM_RegWrite & matchMem;
    // With forwarding only a load in EX cannot supply its result in time.
    assign dataHaz = (FORWARDING != 0) ? (rawEx & IDEX_MemToReg) : (rawEx | rawMem);

    // Zero-latency control: decided from current state and inputs in the same cycle.
    always_comb begin
        ctrl        = CTRL_RUN;
        bubbleCycle = 1'b0;
        if (!rst) begin
            ctrl = CTRL_RUN;
        end else if ((state == ST_HALTED) || mem_halt) begin
            ctrl = CTRL_FREEZE;
        end else if (dmem_busy) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_redirect) begin
            ctrl = CTRL_REDIRECT;
        end else if (dataHaz) begin
            ctrl        = CTRL_BUBBLE;
            bubbleCycle = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RUN;
            waitCnt    <= 8'd0;
            stallCnt   <= '0;
            memTimeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_halt) begin
                        state <= ST_HALTED;
                    end else if (dmem_busy) begin
                        state <= ST_MEMWAIT;
                    end
                end
                ST_MEMWAIT: begin
                    if (!dmem_busy) begin
                        state <= mem_halt ? ST_HALTED : ST_RUN;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase

            if (dmem_busy) begin
                if (waitCnt != 8'hFF) begin
                    waitCnt <= waitCnt + 8'd1;
                end
                if (waitCnt >= WAIT_LAST) begin
                    memTimeout <= 1'b1;
                end
            end else begin
                waitCnt <= 8'd0;
            end

            if (bubbleCycle && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign PC_enable    = ctrl.pcEnable;
    assign IFID_enable  = ctrl.ifidEnable;
    assign IFID_flush   = ctrl.ifidFlush;
    assign IDEX_enable  = ctrl.idexEnable;
    assign IDEX_flush   = ctrl.idexFlush;
    assign EXMEM_enable = ctrl.exmemEnable;
    assign MEMWB_enable = ctrl.memwbEnable;
    assign halted       = (state == ST_HALTED);
    assign mem_timeout  = memTimeout;
    assign stall_cnt    = stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - bench for hazard_stall_ctrl, both forwarding variants side by side
module tb_hazard_stall_ctrl;

    localparam logic [6:0] C_RUN    = 7'b1101011;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_BUBBLE = 7'b0001111;
    localparam int MAXW    = 64;
    localparam int CNT_MAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] id_rs, id_rt, IDEX_WriteRegSel, EXMEM_WriteRegSel;
    logic       id_rs_used, id_rt_used, IDEX_RegWrite, IDEX_MemToReg, EXMEM_RegWrite;
    logic       ex_redirect, dmem_busy, mem_halt;

    logic        pcF1, ifeF1, iffF1, ideF1, idfF1, exeF1, mweF1, haltF1, toF1;
    logic        pcF0, ifeF0, iffF0, ideF0, idfF0, exeF0, mweF0, haltF0, toF0;
    logic [15:0] cntF1, cntF0;

    hazard_stall_ctrl #(.FORWARDING(1), .MAX_WAIT(MAXW), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
        .id_rt_used(id_rt_used), .IDEX_WriteRegSel(IDEX_WriteRegSel),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemToReg(IDEX_MemToReg),
        .EXMEM_WriteRegSel(EXMEM_WriteRegSel), .EXMEM_RegWrite(EXMEM_RegWrite),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .mem_halt(mem_halt),
        .PC_enable(pcF1), .IFID_enable(ifeF1), .IFID_flush(iffF1), .IDEX_enable(ideF1),
        .IDEX_flush(idfF1), .EXMEM_enable(exeF1), .MEMWB_enable(mweF1),
        .halted(haltF1), .mem_timeout(toF1), .stall_cnt(cntF1));

    hazard_stall_ctrl #(.FORWARDING(0), .MAX_WAIT(MAXW), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
        .id_rt_used(id_rt_used), .IDEX_WriteRegSel(IDEX_WriteRegSel),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemToReg(IDEX_MemToReg),
        .EXMEM_WriteRegSel(EXMEM_WriteRegSel), .EXMEM_RegWrite(EXMEM_RegWrite),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .mem_halt(mem_halt),
        .PC_enable(pcF0), .IFID_enable(ifeF0), .IFID_flush(iffF0), .IDEX_enable(ideF0),
        .IDEX_flush(idfF0), .EXMEM_enable(exeF0), .MEMWB_enable(mweF0),
        .halted(haltF0), .mem_timeout(toF0), .stall_cnt(cntF0));

    wire [6:0] ctrlF1 = {pcF1, ifeF1, iffF1, ideF1, idfF1, exeF1, mweF1};
    wire [6:0] ctrlF0 = {pcF0, ifeF0, iffF0, ideF0, idfF0, exeF0, mweF0};

    int  errors = 0;
    int  checks = 0;
    bit  mHalted, mWaiting, mTimeout;
    int  mWait, mStallF1, mStallF0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] expCtrl(input bit fwd);
        bit usesEx, usesMem, haz;
        usesEx  = (id_rs_used && id_rs == IDEX_WriteRegSel) || (id_rt_used && id_rt == IDEX_WriteRegSel);
        usesMem = (id_rs_used && id_rs == EXMEM_WriteRegSel) || (id_rt_used && id_rt == EXMEM_WriteRegSel);
        if (fwd) haz = IDEX_RegWrite && usesEx && IDEX_MemToReg;
        else     haz = (IDEX_RegWrite && usesEx) || (EXMEM_RegWrite && usesMem);
        if (!rst) return C_RUN;
        if (mHalted || mem_halt || dmem_busy) return C_FREEZE;
        if (ex_redirect) return C_REDIR;
        if (haz) return C_BUBBLE;
        return C_RUN;
    endfunction

    task automatic cycle();
        @(negedge clk);
        chk("ctrl_fwd", 32'(ctrlF1), 32'(expCtrl(1'b1)));
        chk("ctrl_nofwd", 32'(ctrlF0), 32'(expCtrl(1'b0)));
        chk("halted_fwd", 32'(haltF1), 32'(mHalted));
        chk("halted_nofwd", 32'(haltF0), 32'(mHalted));
        chk("timeout_fwd", 32'(toF1), 32'(mTimeout));
        chk("timeout_nofwd", 32'(toF0), 32'(mTimeout));
        chk("stallcnt_fwd", 32'(cntF1), 32'(mStallF1));
        chk("stallcnt_nofwd", 32'(cntF0), 32'(mStallF0));
        @(posedge clk);
        if (!rst) begin
            mHalted = 0; mWaiting = 0; mTimeout = 0; mWait = 0; mStallF1 = 0; mStallF0 = 0;
        end else begin
            if (expCtrl(1'b1) == C_BUBBLE && mStallF1 < CNT_MAX) mStallF1++;
            if (expCtrl(1'b0) == C_BUBBLE && mStallF0 < CNT_MAX) mStallF0++;
            if (!mHalted) begin
                if (!mWaiting) begin
                    if (mem_halt) mHalted = 1;
                    else if (dmem_busy) mWaiting = 1;
                end else if (!dmem_busy) begin
                    mWaiting = 0;
                    if (mem_halt) mHalted = 1;
                end
            end
            if (dmem_busy) begin
                if (mWait < 255) mWait++;
                if (mWait >= MAXW) mTimeout = 1;
            end else begin
                mWait = 0;
            end
        end
        #1;
    endtask

    task automatic clearIn();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        IDEX_WriteRegSel = 0; IDEX_RegWrite = 0; IDEX_MemToReg = 0;
        EXMEM_WriteRegSel = 0; EXMEM_RegWrite = 0;
        ex_redirect = 0; dmem_busy = 0; mem_halt = 0;
    endtask

    task automatic randIn(input bit allowHalt);
        id_rs = 3'($urandom); id_rt = 3'($urandom);
        id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
        IDEX_WriteRegSel = 3'($urandom); IDEX_RegWrite = 1'($urandom);
        IDEX_MemToReg = 1'($urandom);
        EXMEM_WriteRegSel = 3'($urandom); EXMEM_RegWrite = 1'($urandom);
        ex_redirect = ($urandom_range(0, 3) == 0);
        dmem_busy = ($urandom_range(0, 5) == 0);
        mem_halt = allowHalt && ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mHalted = 0; mWaiting = 0; mTimeout = 0; mWait = 0; mStallF1 = 0; mStallF0 = 0;
        rst = 0;
        clearIn();
        repeat (3) begin randIn(1'b1); cycle(); end
        chk("reset_cnt", 32'(cntF1), 32'd0);
        rst = 1;
        clearIn();
        cycle();

        // Load-use with forwarding: one bubble, then no stall once EX is not a load
        IDEX_RegWrite = 1; IDEX_MemToReg = 1; IDEX_WriteRegSel = 3; id_rs = 3; id_rs_used = 1;
        cycle();
        chk("loaduse_cnt", 32'(cntF1), 32'd1);
        IDEX_MemToReg = 0;
        cycle();
        chk("alu_nostall_cnt", 32'(cntF1), 32'd1);
        clearIn();

        // RAW against MEM without forwarding, then same with rt unused
        EXMEM_RegWrite = 1; EXMEM_WriteRegSel = 5; id_rt = 5; id_rt_used = 1;
        cycle();
        id_rt_used = 0;
        cycle();

        // Redirect beats a data hazard
        id_rt_used = 1; ex_redirect = 1;
        IDEX_RegWrite = 1; IDEX_MemToReg = 1; IDEX_WriteRegSel = 5;
        cycle();
        clearIn();

        repeat (400) begin randIn(1'b1); if ($urandom_range(0, 31) == 0) rst = 0; else rst = 1; cycle(); end
        rst = 0; clearIn(); cycle(); rst = 1;

        // Long memory wait with a queued redirect and hazard
        dmem_busy = 1; ex_redirect = 1;
        IDEX_RegWrite = 1; IDEX_MemToReg = 1; IDEX_WriteRegSel = 2; id_rs = 2; id_rs_used = 1;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (i == MAXW - 2) chk("timeout_before", 32'(toF1), 32'd0);
            if (i == MAXW - 1) chk("timeout_after", 32'(toF1), 32'd1);
        end
        dmem_busy = 0;
        cycle();
        chk("redir_after_busy_flush", 32'(iffF1), 32'd1);
        ex_redirect = 0;
        repeat (3) cycle();
        chk("timeout_sticky", 32'(toF0), 32'd1);

        // Halt is terminal until reset
        clearIn();
        mem_halt = 1;
        cycle();
        mem_halt = 0;
        chk("halted_next", 32'(haltF1), 32'd1);
        repeat (6) begin randIn(1'b0); ex_redirect = 1; cycle(); end
        rst = 0; clearIn(); cycle(); rst = 1;
        cycle();
        chk("post_reset_halted", 32'(haltF0), 32'd0);
        chk("post_reset_cnt", 32'(cntF0), 32'd0);

        // Stall counter saturation
        IDEX_RegWrite = 1; IDEX_MemToReg = 1; IDEX_WriteRegSel = 4; id_rt = 4; id_rt_used = 1;
        repeat (CNT_MAX + 1) cycle();
        chk("sat_fwd", 32'(cntF1), 32'(CNT_MAX));
        chk("sat_nofwd", 32'(cntF0), 32'(CNT_MAX));
        clearIn();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline control block that drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects RAW hazards between the instruction in ID and older instructions in EX/MEM, and inserts bubbles into ID/EX.
- Squashes wrong-path instructions on an EX redirect.
- Freezes the whole pipe while data memory is busy.
- Latches a terminal HALTED state.
- Keeps a saturating stall counter and a sticky memory-timeout flag.

Parameters:
FORWARDING, 1, 1 = EX/MEM forwarding exists so only load-use stalls; 0 = any RAW against EX or MEM stalls.
MAX_WAIT, 64, dmem_busy cycles before mem_timeout is set; range 1..255.
CNT_W, 16, width of stall_cnt.

Ports:
clk  input  1  system clock
rst  input  1  reset; active-low, synchronous
id_rs  input  3  source reg 1 of instruction in ID
id_rs_used  input  1  id_rs is actually read
id_rt  input  3  source reg 2 of instruction in ID
id_rt_used  input  1  id_rt is actually read
IDEX_WriteRegSel  input  3  destination of instruction in EX
IDEX_RegWrite  input  1  EX instruction writes a register
IDEX_MemToReg  input  1  EX instruction is a load
EXMEM_WriteRegSel  input  3  destination of instruction in MEM
EXMEM_RegWrite  input  1  MEM instruction writes a register
ex_redirect  input  1  taken branch/jump resolved in EX
dmem_busy  input  1  data memory not ready this cycle
mem_halt  input  1  HALT instruction in MEM, committing this cycle
PC_enable  output  1  PC update enable
IFID_enable  output  1  IF/ID load enable
IFID_flush  output  1  IF/ID clear
IDEX_enable  output  1  ID/EX load enable
IDEX_flush  output  1  ID/EX clear (bubble)
EXMEM_enable  output  1  EX/MEM load enable
MEMWB_enable  output  1  MEM/WB load enable
halted  output  1  core halted
mem_timeout  output  1  sticky: dmem_busy exceeded MAX_WAIT
stall_cnt  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- States: RUN, MEMWAIT, HALTED; 2-bit state register. Control outputs are combinational from state and inputs (zero-latency stall). Counters and flags are registered.
- Reset (rst=0 at posedge): state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0, halted=0.
  - While rst=0, all enables=1, all flushes=0.
- Hazard terms:
  - match_X = (id_rs_used & id_rs==X) | (id_rt_used & id_rt==X).
  - raw_ex = IDEX_RegWrite & match(IDEX_WriteRegSel).
  - raw_mem = EXMEM_RegWrite & match(EXMEM_WriteRegSel).
  - data_haz = FORWARDING ? (raw_ex & IDEX_MemToReg) : (raw_ex | raw_mem).
- Output priority, highest first:
  1. HALTED or mem_halt: all enables 0, flushes 0.
  2. dmem_busy: all enables 0, flushes 0 (full freeze; EX contents including any pending redirect are held).
  3. ex_redirect: all enables 1, IFID_flush=1, IDEX_flush=1. Redirect overrides data_haz because the ID instruction is wrong-path.
  4. data_haz: PC_enable=0, IFID_enable=0, IDEX_enable=1, IDEX_flush=1, EXMEM_enable=1, MEMWB_enable=1.
  5. Otherwise: all enables 1, flushes 0.
- Transitions:
  - RUN -> HALTED on mem_halt.
  - RUN -> MEMWAIT on dmem_busy.
  - MEMWAIT -> RUN when dmem_busy=0. That cycle is evaluated by priorities 3-5.
  - MEMWAIT -> HALTED if mem_halt and !dmem_busy.
  - HALTED is left only by reset. halted=1 from the cycle after the mem_halt edge.
- wait_cnt (8-bit):
  - Increments each cycle dmem_busy=1; clears when dmem_busy=0.
  - Saturates at 255.
  - On reaching MAX_WAIT, mem_timeout is set and stays set until reset. Its value does not alter control outputs.
- stall_cnt:
  - +1 on each cycle where priority 4 is the active case.
  - Does not count freeze, redirect or halt cycles.
  - Saturates at 2^CNT_W-1, no wrap.
- Register 0 is not special-cased: a match on reg 0 stalls.

Decomposition:
- Shared pipeline package holds:
  - state encodings (RUN=0, MEMWAIT=1, HALTED=2)
  - REG_SEL_W=3
  - the control-output bundle ordering
- One natural sub-module: hazard_match (pure compare of id_rs/id_rt against a destination, producing match_X). Instantiated twice, for EX and MEM.

Test Plan:
- FORWARDING=1, IDEX_MemToReg=1, IDEX_WriteRegSel=3, IDEX_RegWrite=1, id_rs=3, id_rs_used=1 -> PC_enable=0, IFID_enable=0, IDEX_flush=1 for one cycle, stall_cnt 0->1; with IDEX_MemToReg=0 -> no stall.
- FORWARDING=0, EXMEM_RegWrite=1, EXMEM_WriteRegSel=5, id_rt=5, id_rt_used=1 -> stall. Same with id_rt_used=0 -> all enables 1.
- ex_redirect=1 together with data_haz=1 -> IFID_flush=1, IDEX_flush=1, PC_enable=1, stall_cnt unchanged.
- dmem_busy held 70 cycles, MAX_WAIT=64 -> all enables 0 throughout, mem_timeout rises after the 64th busy cycle and stays 1 after busy drops. A queued ex_redirect is then taken on the first non-busy cycle.
- mem_halt=1 for one cycle -> halted=1 next cycle; all enables stay 0 despite ex_redirect/data_haz until rst=0. After reset, all outputs are back at reset values.
- Force 65535 stall cycles (CNT_W=16), then one more -> stall_cnt holds 65535.
